// File: rtl/outchan_arbiter.sv
// outchan_arbiter: round-robin sharing of one byte-serial transmitter
// among NREQ requesters, with launch/settle/wait handshake and watchdog.
module outchan_arbiter #(
    parameter int          NREQ    = 4,
    parameter int          IDW     = 2,
    parameter logic [23:0] TIMEOUT = 24'd2000000
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NREQ-1:0]   req,
    input  logic [8*NREQ-1:0] req_byte,
    output logic [NREQ-1:0]   done,
    output logic              tx_start,
    output logic [7:0]        tx_byte,
    input  logic              tx_ready,
    output logic              busy,
    output logic [IDW-1:0]    owner,
    output logic              timeout_err
);
    localparam int CW = IDW + 1;

    typedef enum logic [2:0] {
        IDLE,
        LAUNCH,
        SETTLE,
        WAIT,
        RELEASE
    } state_e;

    state_e          state_q, state_d;
    logic [IDW-1:0]  owner_q, owner_d;
    logic [IDW-1:0]  last_q, last_d;
    logic [IDW-1:0]  win;
    logic [7:0]      byte_q, byte_d;
    logic [23:0]     wdog_q, wdog_d;
    logic            terr_q, terr_d;
    logic            start_q, start_d;
    logic [NREQ-1:0] done_q, done_d;
    logic [CW-1:0]   cand;
    logic            found;

    // Scan last+1, last+2, ... wrapping at NREQ rather than 2^IDW
    always_comb begin
        found = 1'b0;
        win   = '0;
        cand  = '0;
        for (int i = 1; i <= NREQ; i++) begin
            cand = {1'b0, last_q} + CW'(i);
            if (cand >= CW'(NREQ)) begin
                cand = cand - CW'(NREQ);
            end
            if (!found && req[cand[IDW-1:0]]) begin
                found = 1'b1;
                win   = cand[IDW-1:0];
            end
        end
    end

    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        last_d  = last_q;
        byte_d  = byte_q;
        wdog_d  = wdog_q;
        terr_d  = terr_q;
        start_d = 1'b0;
        done_d  = '0;
        unique case (state_q)
            IDLE: begin
                if (found && tx_ready) begin
                    owner_d = win;
                    byte_d  = req_byte[8*win +: 8];
                    start_d = 1'b1;
                    state_d = LAUNCH;
                end
            end
            LAUNCH: begin
                state_d = SETTLE;
            end
            // Transmitter ready may lag start by a cycle; not sampled here
            SETTLE: begin
                wdog_d  = '0;
                state_d = WAIT;
            end
            WAIT: begin
                if (tx_ready) begin
                    done_d  = NREQ'(1) << owner_q;
                    state_d = RELEASE;
                end else begin
                    if (wdog_q != '1) begin
                        wdog_d = wdog_q + 24'd1;
                    end
                    if (TIMEOUT != '0 && wdog_q == TIMEOUT - 24'd1) begin
                        terr_d  = 1'b1;
                        done_d  = NREQ'(1) << owner_q;
                        state_d = RELEASE;
                    end
                end
            end
            RELEASE: begin
                last_d  = owner_q;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            owner_q <= '0;
            last_q  <= IDW'(NREQ - 1);
            byte_q  <= '0;
            wdog_q  <= '0;
            terr_q  <= 1'b0;
            start_q <= 1'b0;
            done_q  <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            last_q  <= last_d;
            byte_q  <= byte_d;
            wdog_q  <= wdog_d;
            terr_q  <= terr_d;
            start_q <= start_d;
            done_q  <= done_d;
        end
    end

    assign tx_start    = start_q;
    assign done        = done_q;
    assign tx_byte     = byte_q;
    assign owner       = owner_q;
    assign timeout_err = terr_q;
    assign busy        = (state_q != IDLE);

endmodule

// File: tb/tb_outchan_arbiter.sv
// Bench for outchan_arbiter: table-driven transfers, a launch scoreboard,
// and hand sequences for round-robin, fairness, byte hold and reset.
module tb_outchan_arbiter;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [3:0]  req = '0;
    logic [31:0] req_byte = '0;
    logic [3:0]  done;
    logic        tx_start;
    logic [7:0]  tx_byte;
    logic        tx_ready = 1'b1;
    logic        busy;
    logic [1:0]  owner;
    logic        timeout_err;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [1:0] o;
        logic [7:0] b;
    } exp_t;

    typedef struct {
        logic [3:0]  rq;
        logic [31:0] bytes;
        int          lowc;
        logic [1:0]  eo;
        logic [7:0]  eb;
        logic        et;
    } vec_t;

    exp_t exp_q[$];
    vec_t tbl[10];

    outchan_arbiter #(
        .NREQ(4),
        .IDW(2),
        .TIMEOUT(24'd16)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .req(req),
        .req_byte(req_byte),
        .done(done),
        .tx_start(tx_start),
        .tx_byte(tx_byte),
        .tx_ready(tx_ready),
        .busy(busy),
        .owner(owner),
        .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Every launch must match the oldest expected grant
    always @(negedge clk) begin
        if (rst_n && tx_start) begin
            if (exp_q.size() == 0) begin
                chk("launch_unexpected", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("launch_owner", 32'(owner), 32'(e.o));
                chk("launch_byte", 32'(tx_byte), 32'(e.b));
            end
        end
    end

    task automatic do_reset();
        rst_n = 1'b0;
        req = '0;
        tx_ready = 1'b1;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic wait_idle();
        int k;
        k = 0;
        while (busy && k < 40) begin
            @(negedge clk);
            k++;
        end
        chk("idle_reached", 32'(busy), 32'd0);
    endtask

    task automatic wait_launch(input string nm);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!tx_start && n < 10);
        chk(nm, n, 1);
    endtask

    task automatic txn(input vec_t v);
        int k;
        int exp_k;
        logic got;
        req = v.rq;
        req_byte = v.bytes;
        tx_ready = 1'b1;
        exp_q.push_back('{v.eo, v.eb});
        wait_launch("grant_latency");
        if (!tx_start) return;
        tx_ready = 1'b0;
        got = 1'b0;
        k = 0;
        while (!got && k < 40) begin
            @(negedge clk);
            k++;
            if (k == 1) chk("start_width", 32'(tx_start), 32'd0);
            if (done != '0) got = 1'b1;
            else if (k == 2 + v.lowc) tx_ready = 1'b1;
        end
        exp_k = (v.lowc >= 16) ? 18 : v.lowc + 3;
        chk("done_cycle", k, exp_k);
        chk("done_vec", 32'(done), 32'(4'b0001 << v.eo));
        chk("byte_hold", 32'(tx_byte), 32'(v.eb));
        chk("timeout_err", 32'(timeout_err), 32'(v.et));
        req = '0;
        tx_ready = 1'b1;
        @(negedge clk);
        chk("done_width", 32'(done), 32'd0);
        chk("busy_after", 32'(busy), 32'd0);
    endtask

    initial begin
        #2000000;
        $display("FAIL global_timeout: got hang expected finish");
        $fatal(1);
    end

    initial begin
        int n;
        int k;
        int d3;

        tbl[0] = '{4'b0100, 32'hD341B1A0, 10, 2'd2, 8'h41, 1'b0};
        tbl[1] = '{4'b1001, 32'hD3C2B1A0, 5, 2'd3, 8'hD3, 1'b0};
        tbl[2] = '{4'b0011, 32'hD3C2B1A0, 0, 2'd0, 8'hA0, 1'b0};
        tbl[3] = '{4'b0011, 32'hD3C2B1A0, 1, 2'd1, 8'hB1, 1'b0};
        tbl[4] = '{4'b0101, 32'hD3C2B1A0, 3, 2'd2, 8'hC2, 1'b0};
        tbl[5] = '{4'b1111, 32'hD3C2B1A0, 0, 2'd3, 8'hD3, 1'b0};
        tbl[6] = '{4'b1110, 32'hD3C2B1A0, 2, 2'd1, 8'hB1, 1'b0};
        tbl[7] = '{4'b0001, 32'hD3C2B1A0, 0, 2'd0, 8'hA0, 1'b0};
        tbl[8] = '{4'b0100, 32'hD3C2B1A0, 99, 2'd2, 8'hC2, 1'b1};
        tbl[9] = '{4'b1000, 32'hD3C2B1A0, 0, 2'd3, 8'hD3, 1'b1};

        do_reset();
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_start", 32'(tx_start), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_owner", 32'(owner), 32'd0);
        chk("rst_byte", 32'(tx_byte), 32'd0);
        chk("rst_terr", 32'(timeout_err), 32'd0);

        foreach (tbl[i]) txn(tbl[i]);

        // Continuous requests from all four: strict rotation
        do_reset();
        req_byte = 32'h33323130;
        exp_q.push_back('{2'd0, 8'h30});
        exp_q.push_back('{2'd1, 8'h31});
        exp_q.push_back('{2'd2, 8'h32});
        exp_q.push_back('{2'd3, 8'h33});
        exp_q.push_back('{2'd0, 8'h30});
        req = 4'b1111;
        n = 0;
        k = 0;
        while (n < 5 && k < 60) begin
            @(negedge clk);
            k++;
            if (tx_start) n++;
        end
        req = '0;
        chk("rr_launches", n, 5);
        wait_idle();

        // req0 held, req3 arrives once: served next
        req = 4'b0001;
        exp_q.push_back('{2'd0, 8'h30});
        n = 0;
        k = 0;
        d3 = 0;
        while (n < 3 && k < 60) begin
            @(negedge clk);
            k++;
            if (done[3]) begin
                req[3] = 1'b0;
                d3++;
            end
            if (tx_start) begin
                n++;
                if (n == 1) begin
                    req[3] = 1'b1;
                    exp_q.push_back('{2'd3, 8'h33});
                    exp_q.push_back('{2'd0, 8'h30});
                end
            end
        end
        req = '0;
        chk("fair_launches", n, 3);
        chk("fair_done3", d3, 1);
        wait_idle();

        // Byte changes after the grant must not reach tx_byte
        req_byte = 32'h33323155;
        req = 4'b0001;
        exp_q.push_back('{2'd0, 8'h55});
        wait_launch("hold_latency");
        @(negedge clk);
        req_byte[7:0] = 8'hAA;
        k = 0;
        while (done == '0 && k < 20) begin
            chk("hold_byte", 32'(tx_byte), 32'h55);
            @(negedge clk);
            k++;
        end
        chk("hold_done", 32'(done), 32'b0001);
        chk("hold_byte_done", 32'(tx_byte), 32'h55);
        req = '0;
        wait_idle();

        // Asynchronous reset in the middle of WAIT
        req_byte = 32'h33323130;
        req = 4'b0100;
        exp_q.push_back('{2'd2, 8'h32});
        wait_launch("ar_latency");
        tx_ready = 1'b0;
        repeat (4) @(negedge clk);
        chk("ar_busy_before", 32'(busy), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("ar_busy", 32'(busy), 32'd0);
        chk("ar_start", 32'(tx_start), 32'd0);
        chk("ar_done", 32'(done), 32'd0);
        chk("ar_owner", 32'(owner), 32'd0);
        req = 4'b1111;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        tx_ready = 1'b1;
        exp_q.push_back('{2'd0, 8'h30});
        wait_launch("ar_first_grant");
        req = '0;
        wait_idle();

        chk("scoreboard_empty", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
